// File: rtl/fft_result_reader.sv
// Streams a finished FFT frame out of the result RAM as valid/ready samples.
// Define FFT_BITREV_EN to read a bit-reversed RAM in natural frequency order.
module fft_result_reader #(
  parameter int unsigned N_POINTS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_finish,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] rd_idx;
  logic              inflight;
  logic              inflight_last;
  logic              sk_valid;
  logic              sk_last;
  logic [DATA_W-1:0] sk_data;
  logic              pop;
  logic              last_rd;
  logic [2:0]        level;

  // Occupancy after this cycle's pop, including the word returning from RAM now.
  assign pop     = out_valid & out_ready;
  assign level   = 3'(out_valid) + 3'(sk_valid) + 3'(inflight) - 3'(pop);
  assign last_rd = (rd_idx == ADDR_W'(N_POINTS - 1));

`ifdef FFT_BITREV_EN
  always_comb begin
    rd_addr = '0;
    for (int b = 0; b < int'(ADDR_W); b++) begin
      rd_addr[b] = rd_idx[int'(ADDR_W) - 1 - b];
    end
  end
`else
  assign rd_addr = rd_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A read may issue only when its data is guaranteed a buffer slot next cycle.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (fft_finish) begin
          state_next = READ;
        end
      end
      READ: begin
        rd_en = (level < 3'd2);
        if (rd_en && last_rd) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (level == 3'd0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      sk_valid      <= 1'b0;
      sk_data       <= '0;
      sk_last       <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      busy          <= (state_next != IDLE);
      inflight      <= rd_en;
      inflight_last <= rd_en & last_rd;
      if (fft_finish && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      if (rd_en) begin
        rd_idx <= rd_idx + ADDR_W'(1);
      end
      // Head register drives the output; skid entry absorbs a stalled return.
      if (!out_valid || pop) begin
        if (sk_valid) begin
          out_valid <= 1'b1;
          out_data  <= sk_data;
          out_last  <= sk_last;
          sk_valid  <= inflight;
          if (inflight) begin
            sk_data <= rd_data;
            sk_last <= inflight_last;
          end
        end else begin
          out_valid <= inflight;
          if (inflight) begin
            out_data <= rd_data;
            out_last <= inflight_last;
          end
        end
      end else if (inflight) begin
        sk_valid <= 1'b1;
        sk_data  <= rd_data;
        sk_last  <= inflight_last;
      end
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: RAM model, address and sample queues.
// Build with +define+FFT_BITREV_EN to exercise the bit-reversed read order.
module tb_fft_result_reader;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fft_finish;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  fft_result_reader #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fft_finish(fft_finish),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Result RAM: one-cycle read latency
  logic [DW-1:0] ram [N];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } samp_t;

  samp_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            vectors = 0;
  int            errors  = 0;
  int            rx_cnt  = 0;
  logic          held    = 1'b0;
  samp_t         held_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-reversal table for 5 bits, written out by hand
  logic [AW-1:0] brev_tab [N] = '{5'd0, 5'd16, 5'd8, 5'd24, 5'd4, 5'd20, 5'd12, 5'd28,
                                  5'd2, 5'd18, 5'd10, 5'd26, 5'd6, 5'd22, 5'd14, 5'd30,
                                  5'd1, 5'd17, 5'd9, 5'd25, 5'd5, 5'd21, 5'd13, 5'd29,
                                  5'd3, 5'd19, 5'd11, 5'd27, 5'd7, 5'd23, 5'd15, 5'd31};

  function automatic logic [AW-1:0] exp_addr(input int j);
`ifdef FFT_BITREV_EN
    return brev_tab[j];
`else
    return AW'(j);
`endif
  endfunction

  // Monitor: checks reads and accepted samples against the queues
  always @(negedge clk) begin
    samp_t s;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_hold", 32'({out_valid, out_last, out_data}),
              32'({1'b1, held_s.last, held_s.data}));
      end
      held = 1'b0;
      if (rd_en) begin
        if (addr_q.size() == 0) check("unexpected_read", 32'(addr_q.size()), 32'd1);
        else check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 32'(exp_q.size()), 32'd1);
        end else begin
          s = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(s.data));
          check("out_last", 32'(out_last), 32'(s.last));
        end
      end else if (out_valid) begin
        held   = 1'b1;
        held_s = {out_last, out_data};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [DW-1:0] base);
    samp_t s;
    for (int i = 0; i < int'(N); i++) ram[i] = base + DW'(i);
    for (int j = 0; j < int'(N); j++) begin
      addr_q.push_back(exp_addr(j));
      s.last = (j == int'(N) - 1);
      s.data = base + DW'(exp_addr(j));
      exp_q.push_back(s);
    end
    fft_finish = 1'b1;
    tick();
    fft_finish = 1'b0;
  endtask

  // mode 0: ready high; 1: toggle then 10-cycle stall; 2: ready high plus
  // a second fft_finish at sample 10
  task automatic run_frame(input int mode, output int cycles, output int first_valid);
    int start, stall_left;
    bit injected;
    start       = rx_cnt;
    stall_left  = 10;
    injected    = 1'b0;
    cycles      = 1;
    first_valid = -1;
    while (busy && cycles < 600) begin
      fft_finish = 1'b0;
      if (mode == 1) begin
        if (rx_cnt - start < 12) out_ready = (cycles % 2 == 0);
        else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = 1'b1;
      end else begin
        out_ready = 1'b1;
        if (mode == 2 && !injected && rx_cnt - start == 10) begin
          fft_finish = 1'b1;
          injected   = 1'b1;
        end
      end
      tick();
      cycles++;
      if (first_valid < 0 && out_valid) first_valid = cycles;
    end
    fft_finish = 1'b0;
    out_ready  = 1'b1;
    check("frame_done", 32'(busy), 32'd0);
    check("frame_samples", 32'(rx_cnt - start), N);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc, fv, start;
    rst        = 1'b1;
    fft_finish = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Full-rate frame, RAM[i]=i
    start_frame(16'h0000);
    check("busy_after_finish", 32'(busy), 32'd1);
    check("no_early_valid", 32'(out_valid), 32'd0);
    run_frame(0, cyc, fv);
    check("first_valid_cycle", 32'(fv), 32'd3);
    check("frame_cycles", 32'(cyc), 32'd35);
    check("overrun_clean", 32'(overrun), 32'd0);
    repeat (2) tick();

    // Backpressure: toggling ready then a long stall
    start_frame(16'h1100);
    run_frame(1, cyc, fv);
    check("overrun_after_stall", 32'(overrun), 32'd0);
    repeat (2) tick();

    // Second fft_finish mid-frame
    start_frame(16'h2200);
    run_frame(2, cyc, fv);
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_frame_cycles", 32'(cyc), 32'd35);
    repeat (5) tick();
    check("no_restart", 32'(busy), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset at sample 7 aborts the frame and clears overrun
    start_frame(16'h3300);
    start = rx_cnt;
    cyc   = 0;
    while (rx_cnt - start < 7 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reach_sample7", 32'(rx_cnt - start), 32'd7);
    rst = 1'b1;
    tick();
    exp_q.delete();
    addr_q.delete();
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    check("abort_rd_en", 32'(rd_en), 32'd0);
    repeat (3) tick();
    check("abort_silent", 32'(out_valid), 32'd0);

    // Fresh frame after abort, then a back-to-back frame
    start_frame(16'h4400);
    run_frame(0, cyc, fv);
    start_frame(16'h5500);
    run_frame(0, cyc, fv);
    check("b2b_frame_cycles", 32'(cyc), 32'd35);
    check("b2b_overrun", 32'(overrun), 32'd0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
